// File: rtl/ysyx_24100005_pkg.sv
// Shared sizing constants for the register file slice.
package ysyx_24100005_pkg;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int ZERO_REG      = 0;
endpackage

// File: rtl/ysyx_24100005_reg.sv
// Single storage word: async active-low clear, loads din when wen is high.
module ysyx_24100005_reg #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dout <= RESET_VAL;
        else if (wen)
            dout <= din;
    end
endmodule

// File: rtl/ysyx_24100005_register_file.sv
// 2-read/1-write register file with hardwired zero register.
// Optional same-cycle write-to-read forwarding: define YSYX_24100005_RF_BYPASS_EN.
module ysyx_24100005_register_file
    import ysyx_24100005_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic [DATA_WIDTH-1:0] rs1data,
    output logic [DATA_WIDTH-1:0] rs2data
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // x0 has no storage; it is tied to zero here.
    assign regs[ZERO_REG] = '0;

    genvar i;
    generate
        for (i = 1; i < NUM_REGS; i++) begin : g_word
            logic word_wen;
            assign word_wen = wen && (waddr == ADDR_WIDTH'(i));
            ysyx_24100005_reg #(
                .WIDTH     (DATA_WIDTH),
                .RESET_VAL ('0)
            ) u_reg (
                .clk  (clk),
                .rst  (rst),
                .din  (wdata),
                .dout (regs[i]),
                .wen  (word_wen)
            );
        end
    endgenerate

`ifdef YSYX_24100005_RF_BYPASS_EN
    logic fwd_live;
    assign fwd_live = wen && rst && (waddr != ADDR_WIDTH'(ZERO_REG));

    always_comb begin
        rs1data = regs[rs1addr];
        rs2data = regs[rs2addr];
        if (fwd_live && (rs1addr == waddr))
            rs1data = wdata;
        if (fwd_live && (rs2addr == waddr))
            rs2data = wdata;
    end
`else
    assign rs1data = regs[rs1addr];
    assign rs2data = regs[rs2addr];
`endif
endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
// Self-checking bench: directed scenarios then random traffic against an array model.
module tb_ysyx_24100005_register_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1addr;
    logic [4:0]  rs2addr;
    logic [31:0] rs1data;
    logic [31:0] rs2data;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    ysyx_24100005_register_file #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .rs1addr (rs1addr),
        .rs2addr (rs2addr),
        .rs1data (rs1data),
        .rs2data (rs2data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference read: storage array, x0 = 0, optional forwarding of the pending write.
    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'd0 : model[a];
`ifdef YSYX_24100005_RF_BYPASS_EN
        if (wen && rst && waddr != 5'd0 && a == waddr)
            v = wdata;
`endif
        return v;
    endfunction

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        rs1addr = a;
        rs2addr = b;
        #1;
    endtask

    // Drive one write at the falling edge, let it land on the rising edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        if (rst && a != 5'd0) model[a] = d;
        #1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; rs1addr = '0; rs2addr = '0;
        for (int k = 0; k < 32; k++) model[k] = 32'd0;

        // Reset asserted mid-cycle, all words read zero without any clock edge
        #2 rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rd(5'(k), 5'(31 - k));
            chk($sformatf("reset_rs1_x%0d", k), rs1data, 32'd0);
            chk($sformatf("reset_rs2_x%0d", 31 - k), rs2data, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // First write after reset release lands on the next edge
        wr(5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd5);
        chk("wr_x5_rs1", rs1data, 32'hDEADBEEF);
        chk("wr_x5_rs2", rs2data, 32'hDEADBEEF);

        wr(5'd0, 32'hFFFFFFFF);
        rd(5'd0, 5'd0);
        chk("x0_rs1", rs1data, 32'd0);
        chk("x0_rs2", rs2data, 32'd0);

        // wen low leaves x7 intact
        wr(5'd7, 32'h12345678);
        @(negedge clk);
        wen = 1'b0; waddr = 5'd7; wdata = 32'd0;
        @(posedge clk); #1;
        rd(5'd7, 5'd5);
        chk("wen_low_x7", rs1data, 32'h12345678);
        chk("wen_low_x5", rs2data, 32'hDEADBEEF);

        // Same-cycle read of the address being written
        wr(5'd3, 32'd1);
        @(negedge clk);
        wen = 1'b1; waddr = 5'd3; wdata = 32'd2;
        rd(5'd3, 5'd3);
`ifdef YSYX_24100005_RF_BYPASS_EN
        chk("same_cycle_pre", rs1data, 32'd2);
`else
        chk("same_cycle_pre", rs1data, 32'd1);
`endif
        @(posedge clk);
        model[3] = 32'd2;
        #1;
        chk("same_cycle_post", rs1data, 32'd2);
        @(negedge clk);
        wen = 1'b0;

        // Reset coinciding with a write: write is lost, everything clears
        wr(5'd9, 32'hA5A5A5A5);
        rd(5'd9, 5'd9);
        chk("x9_held", rs1data, 32'hA5A5A5A5);
        @(negedge clk);
        rst = 1'b0; wen = 1'b1; waddr = 5'd9; wdata = 32'h1;
        #1;
        chk("rst_write_pre", rs1data, 32'd0);
        @(posedge clk); #1;
        chk("rst_write_x9", rs1data, 32'd0);
        rd(5'd5, 5'd7);
        chk("rst_write_x5", rs1data, 32'd0);
        chk("rst_write_x7", rs2data, 32'd0);
        for (int k = 0; k < 32; k++) model[k] = 32'd0;
        @(negedge clk);
        wen = 1'b0; rst = 1'b1;

        // Random traffic against the array model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            wen     = ($urandom_range(0, 3) != 0);
            waddr   = 5'($urandom_range(0, 31));
            wdata   = $urandom;
            rs1addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            rs2addr = ($urandom_range(0, 7) == 0) ? rs1addr : 5'($urandom_range(0, 31));
            #1;
            chk($sformatf("rand%0d_rs1_x%0d", n, rs1addr), rs1data, ref_rd(rs1addr));
            chk($sformatf("rand%0d_rs2_x%0d", n, rs2addr), rs2data, ref_rd(rs2addr));
            @(posedge clk);
            if (wen && waddr != 5'd0) model[waddr] = wdata;
        end

        @(negedge clk);
        wen = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rd(5'(k), 5'(k));
            chk($sformatf("final_x%0d", k), rs1data, ref_rd(5'(k)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_24100005_register_file.md
YSYX_24100005_REGISTER_FILE -- requirements
Module: ysyx_24100005_register_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: address width; register count is 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of each register.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wen, input, 1 bit: write enable.
REQ-006 SHALL have port waddr, input, ADDR_WIDTH bits: write address (instruction rd field).
REQ-007 SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-008 SHALL have port rs1addr, input, ADDR_WIDTH bits: read port 1 address.
REQ-009 SHALL have port rs2addr, input, ADDR_WIDTH bits: read port 2 address.
REQ-010 SHALL have port rs1data, output, DATA_WIDTH bits: read port 1 data.
REQ-011 SHALL have port rs2data, output, DATA_WIDTH bits: read port 2 data.

Function
REQ-012 Each read port SHALL be purely combinational, with zero-cycle latency from address to data.
REQ-013 Reading address 0 SHALL return 0 at all times.
REQ-014 On a rising clk edge with rst high, wen=1 and waddr!=0, register[waddr] SHALL take wdata; the new value is visible on the read ports after that edge.
REQ-015 Writes with wen=0 or waddr=0 SHALL leave all state unchanged.
REQ-016 Both read ports SHALL operate independently, including when they read the same address simultaneously.
REQ-017 Without bypass (REQ-022), a read of waddr in the same cycle as its write SHALL return the old value until the edge.
REQ-018 The block SHALL have no handshake and no state machine; there is one write per cycle.

Reset
REQ-019 When rst is 0, all registers SHALL be cleared to 0 immediately, independent of clk.
REQ-020 While rst is 0, writes SHALL be ignored; rst low overrides wen mid-operation.
REQ-021 After rst returns high, the first write SHALL take effect on the next rising clk edge.

Configuration
REQ-022 With macro YSYX_24100005_RF_BYPASS_EN defined, a read port SHALL return wdata combinationally when wen=1, rst=1, waddr!=0 and its address equals waddr.
REQ-023 Without YSYX_24100005_RF_BYPASS_EN, no forwarding logic SHALL exist and REQ-017 applies.
REQ-024 Bypass SHALL never apply to address 0.

Structure
REQ-025 Shared package ysyx_24100005_pkg SHALL hold the default ADDR_WIDTH (5), the default DATA_WIDTH (32) and the zero-register index constant (0).
REQ-026 Each storage word SHALL be an instance of sub-module ysyx_24100005_reg, with parameters WIDTH and RESET_VAL and ports clk, rst (async active-low), din, dout and wen.
REQ-027 Instances SHALL be generated for indices 1..2**ADDR_WIDTH-1; index 0 is constant 0 with no storage.

Verification
REQ-028 Reset: drive rst=0 mid-cycle, then read all 32 addresses; every address returns 0x00000000 with no clock edge needed.
REQ-029 Write/read: wen=1, waddr=5, wdata=0xDEADBEEF, one edge, then rs1addr=5 and rs2addr=5; both ports return 0xDEADBEEF.
REQ-030 x0: wen=1, waddr=0, wdata=0xFFFFFFFF, one edge; reading address 0 returns 0.
REQ-031 wen low: x7=0x12345678 is held, then wen=0, waddr=7, wdata=0; after the edge x7 still reads 0x12345678.
REQ-032 Same-cycle read: x3=1 is held, write 2 to x3 while rs1addr=3; before the edge rs1data reads 1 without the macro and 2 with YSYX_24100005_RF_BYPASS_EN; after the edge it reads 2.
REQ-033 Reset mid-write: x9=0xA5A5A5A5 is held, pull rst=0 together with wen=1, waddr=9, wdata=0x1, then clock; x9 reads 0 and the write is lost.
